// File: rtl/snn_ctrl_pkg.sv
// rtl/snn_ctrl_pkg.sv - shared SNN control state encoding
package snn_ctrl_pkg;

  // Scheduler state encoding; the loader FSM decodes o_state with these values.
  localparam logic [2:0] STATE_IDLE      = 3'd0;
  localparam logic [2:0] STATE_QUIET     = 3'd1;
  localparam logic [2:0] STATE_TICK      = 3'd2;
  localparam logic [2:0] STATE_WAIT_DONE = 3'd3;
  localparam logic [2:0] STATE_DONE      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = STATE_IDLE,
    S_QUIET     = STATE_QUIET,
    S_TICK      = STATE_TICK,
    S_WAIT_DONE = STATE_WAIT_DONE,
    S_DONE      = STATE_DONE
  } sched_state_e;

endpackage

// File: rtl/quiet_window_cnt.sv
// rtl/quiet_window_cnt.sv - counts consecutive quiet cycles up to a window
module quiet_window_cnt #(
  parameter int QUIET_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_quiet,
  output logic o_window_met
);

  localparam int CW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUIET_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // The window closes on the cycle that is the QUIET_CYCLES-th quiet one in a row.
  assign o_window_met = i_quiet && (r_cnt == LAST);

  // Any non-quiet cycle restarts the window; a met window also restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_quiet || o_window_met) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timestep_scheduler.sv
// rtl/timestep_scheduler.sv - runs N timesteps: wait quiet, tick, collect core done
module timestep_scheduler
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_CORES    = 6,
  parameter int QUIET_CYCLES = 8,
  parameter int STEP_W       = 16,
  parameter int TO_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [STEP_W-1:0]    i_num_steps,
  input  logic [TO_W-1:0]      i_timeout_cycles,
  input  logic                 i_input_buffer_empty,
  input  logic                 i_fwd_buf_empty_all,
  input  logic                 i_grid_busy,
  input  logic [NUM_CORES-1:0] i_core_done,
  output logic                 o_tick,
  output logic                 o_busy,
  output logic                 o_complete,
  output logic                 o_timeout_err,
  output logic [STEP_W-1:0]    o_step_cnt,
  output logic [2:0]           o_state
);

  sched_state_e          r_state;
  sched_state_e          w_next;
  logic                  r_tick;
  logic                  r_busy;
  logic                  r_complete;
  logic                  r_timeout_err;
  logic [STEP_W-1:0]     r_step_cnt;
  logic [STEP_W-1:0]     r_num_steps;
  logic [TO_W-1:0]       r_to_lim;
  logic [TO_W-1:0]       r_to_cnt;
  logic [NUM_CORES-1:0]  r_mask;
  logic                  w_quiet;
  logic                  w_qclr;
  logic                  w_window_met;
  logic                  w_all_done;
  logic                  w_timeout;
  logic [STEP_W-1:0]     w_step_inc;

  assign w_quiet    = i_input_buffer_empty & i_fwd_buf_empty_all & ~i_grid_busy;
  assign w_qclr     = (r_state != S_QUIET) || i_abort;
  assign w_all_done = &(r_mask | i_core_done);
  assign w_timeout  = (r_to_lim != '0) && (r_to_cnt == (r_to_lim - 1'b1));
  assign w_step_inc = r_step_cnt + 1'b1;

  quiet_window_cnt #(
    .QUIET_CYCLES(QUIET_CYCLES)
  ) u_quiet (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_qclr),
    .i_quiet     (w_quiet),
    .o_window_met(w_window_met)
  );

  // Next-state selection; abort overrides every transition, including start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (i_num_steps == '0) ? S_DONE : S_QUIET;
        end
      end
      S_QUIET: begin
        if (w_window_met) begin
          w_next = S_TICK;
        end
      end
      S_TICK: begin
        w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_all_done) begin
          w_next = (w_step_inc == r_num_steps) ? S_DONE : S_QUIET;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (i_abort) begin
      w_next = S_IDLE;
    end
  end

  // State register with outputs registered from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tick     <= (w_next == S_TICK);
      r_busy     <= (w_next != S_IDLE);
      r_complete <= (w_next == S_DONE);
    end
  end

  // Run parameters, step/timeout counters and the per-core done mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
      r_step_cnt    <= '0;
      r_num_steps   <= '0;
      r_to_lim      <= '0;
      r_to_cnt      <= '0;
      r_mask        <= '0;
    end else if (i_abort) begin
      r_to_cnt <= '0;
      r_mask   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_steps   <= i_num_steps;
            r_to_lim      <= i_timeout_cycles;
            r_step_cnt    <= '0;
            r_timeout_err <= 1'b0;
          end
        end
        S_TICK: begin
          r_mask   <= '0;
          r_to_cnt <= '0;
        end
        S_WAIT_DONE: begin
          r_mask   <= r_mask | i_core_done;
          r_to_cnt <= r_to_cnt + 1'b1;
          if (w_all_done) begin
            r_step_cnt <= w_step_inc;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_tick        = r_tick;
  assign o_busy        = r_busy;
  assign o_complete    = r_complete;
  assign o_timeout_err = r_timeout_err;
  assign o_step_cnt    = r_step_cnt;
  assign o_state       = r_state;

endmodule
